// File: rtl/cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_miss_ctrl
// Brief    : Miss sequencer: LRU victim query, dirty writeback, line fill and
//            MRU touch; owns per-way valid/dirty bits and shares the LRU port
//            with hit traffic. Optional macro CACHE_INVALID_FIRST_EN.
// Revision : 1.0
// ============================================================================
module cache_miss_ctrl #(
  parameter int NUM_SET        = 2,
  parameter int WAYS_PER_SET   = 2,
  parameter int TAG_W          = 20,
  parameter int NUM_SET_W      = $clog2(NUM_SET),
  parameter int WAYS_PER_SET_W = $clog2(WAYS_PER_SET)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       miss_req,
  input  logic [NUM_SET_W-1:0]       miss_set,
  input  logic [TAG_W-1:0]           miss_tag,
  input  logic                       miss_is_store,
  output logic                       miss_ready,
  input  logic                       hit_req,
  input  logic [NUM_SET_W-1:0]       hit_set,
  input  logic [WAYS_PER_SET_W-1:0]  hit_way,
  input  logic                       hit_is_store,
  output logic                       hit_stall,
  output logic                       lru_victim_req,
  output logic [NUM_SET_W-1:0]       lru_victim_set,
  input  logic [WAYS_PER_SET_W-1:0]  lru_victim_way,
  output logic                       lru_update_req,
  output logic [NUM_SET_W-1:0]       lru_update_set,
  output logic [WAYS_PER_SET_W-1:0]  lru_update_way,
  output logic [NUM_SET_W-1:0]       tag_rd_set,
  output logic [WAYS_PER_SET_W-1:0]  tag_rd_way,
  input  logic [TAG_W-1:0]           tag_rd_tag,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [TAG_W+NUM_SET_W-1:0] mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rsp_valid,
  output logic                       fill_done,
  output logic [NUM_SET_W-1:0]       fill_set,
  output logic [WAYS_PER_SET_W-1:0]  fill_way,
  output logic [TAG_W-1:0]           fill_tag
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VICTIM    = 3'd1,
    S_WB_REQ    = 3'd2,
    S_WB_WAIT   = 3'd3,
    S_FILL_REQ  = 3'd4,
    S_FILL_WAIT = 3'd5,
    S_UPDATE    = 3'd6
  } state_t;

  state_t                    r_state, w_next;
  logic [NUM_SET_W-1:0]      r_set;
  logic [TAG_W-1:0]          r_tag, r_vtag;
  logic                      r_is_store;
  logic [WAYS_PER_SET_W-1:0] r_way, w_vway;
  logic [WAYS_PER_SET-1:0]   r_valid [NUM_SET];
  logic [WAYS_PER_SET-1:0]   r_dirty [NUM_SET];
  logic                      w_victim_wb;

`ifdef CACHE_INVALID_FIRST_EN
  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_vway = lru_victim_way;
    for (int i = WAYS_PER_SET-1; i >= 0; i--) begin
      if (!r_valid[r_set][i]) w_vway = WAYS_PER_SET_W'(i);
    end
  end
`else
  assign w_vway = lru_victim_way;
`endif

  assign w_victim_wb = r_valid[r_set][w_vway] & r_dirty[r_set][w_vway];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    miss_ready     = 1'b0;
    hit_stall      = 1'b0;
    lru_victim_req = 1'b0;
    lru_victim_set = '0;
    lru_update_req = hit_req;
    lru_update_set = hit_set;
    lru_update_way = hit_way;
    tag_rd_set     = '0;
    tag_rd_way     = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    fill_done      = 1'b0;
    fill_set       = '0;
    fill_way       = '0;
    fill_tag       = '0;
    unique case (r_state)
      S_IDLE: begin
        miss_ready = 1'b1;
        if (miss_req) w_next = S_VICTIM;
      end
      S_VICTIM: begin
        lru_victim_req = 1'b1;
        lru_victim_set = r_set;
        tag_rd_set     = r_set;
        tag_rd_way     = w_vway;
        w_next         = w_victim_wb ? S_WB_REQ : S_FILL_REQ;
      end
      S_WB_REQ: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {r_vtag, r_set};
        if (mem_gnt) w_next = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (mem_rsp_valid) w_next = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {r_tag, r_set};
        if (mem_gnt) w_next = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rsp_valid) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        // Miss completion owns the LRU port; any hit this cycle is refused.
        hit_stall      = hit_req;
        lru_update_req = 1'b1;
        lru_update_set = r_set;
        lru_update_way = r_way;
        fill_done      = 1'b1;
        fill_set       = r_set;
        fill_way       = r_way;
        fill_tag       = r_tag;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_set      <= '0;
      r_tag      <= '0;
      r_vtag     <= '0;
      r_is_store <= 1'b0;
      r_way      <= '0;
      r_valid    <= '{default: '0};
      r_dirty    <= '{default: '0};
    end else begin
      if (r_state == S_IDLE && miss_req) begin
        r_set      <= miss_set;
        r_tag      <= miss_tag;
        r_is_store <= miss_is_store;
      end
      if (hit_req && hit_is_store && r_state != S_UPDATE && r_valid[hit_set][hit_way])
        r_dirty[hit_set][hit_way] <= 1'b1;
      // Victim invalidation is ordered last so it overrides a same-cycle store hit.
      if (r_state == S_VICTIM) begin
        r_way                   <= w_vway;
        r_vtag                  <= tag_rd_tag;
        r_valid[r_set][w_vway]  <= 1'b0;
        r_dirty[r_set][w_vway]  <= 1'b0;
      end
      if (r_state == S_UPDATE) begin
        r_valid[r_set][r_way] <= 1'b1;
        r_dirty[r_set][r_way] <= r_is_store;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_miss_ctrl
// Brief    : Scoreboard bench for cache_miss_ctrl with a directed miss/hit list
//            and a behavioural memory responder.
// Revision : 1.0
// ============================================================================
module tb_cache_miss_ctrl;

`ifdef CACHE_INVALID_FIRST_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clock, reset;
  logic        miss_req, miss_set, miss_is_store, miss_ready;
  logic [19:0] miss_tag;
  logic        hit_req, hit_set, hit_way, hit_is_store, hit_stall;
  logic        lru_victim_req, lru_victim_set, lru_victim_way;
  logic        lru_update_req, lru_update_set, lru_update_way;
  logic        tag_rd_set, tag_rd_way;
  logic [19:0] tag_rd_tag;
  logic        mem_req, mem_we, mem_gnt, mem_rsp_valid;
  logic [20:0] mem_addr;
  logic        fill_done, fill_set, fill_way;
  logic [19:0] fill_tag;

  logic [19:0] tag_mem [2][2];
  logic        lru_way;
  int          gd_cfg, rd_cfg;
  int          chk, err;

  logic [21:0] mem_q  [$];
  logic [21:0] fill_q [$];
  logic [1:0]  hit_q  [$];

  cache_miss_ctrl #(.NUM_SET(2), .WAYS_PER_SET(2), .TAG_W(20)) dut (
    .clock(clock), .reset(reset),
    .miss_req(miss_req), .miss_set(miss_set), .miss_tag(miss_tag),
    .miss_is_store(miss_is_store), .miss_ready(miss_ready),
    .hit_req(hit_req), .hit_set(hit_set), .hit_way(hit_way),
    .hit_is_store(hit_is_store), .hit_stall(hit_stall),
    .lru_victim_req(lru_victim_req), .lru_victim_set(lru_victim_set),
    .lru_victim_way(lru_victim_way),
    .lru_update_req(lru_update_req), .lru_update_set(lru_update_set),
    .lru_update_way(lru_update_way),
    .tag_rd_set(tag_rd_set), .tag_rd_way(tag_rd_way), .tag_rd_tag(tag_rd_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid),
    .fill_done(fill_done), .fill_set(fill_set), .fill_way(fill_way),
    .fill_tag(fill_tag)
  );

  assign lru_victim_way = lru_way;
  assign tag_rd_tag     = tag_mem[tag_rd_set][tag_rd_way];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory: grant after gd_cfg waiting cycles, respond rd_cfg cycles after grant.
  initial begin
    int gwait, pend;
    mem_gnt = 1'b0; mem_rsp_valid = 1'b0; gwait = 0; pend = 0;
    forever begin
      @(posedge clock); #1;
      mem_gnt = 1'b0; mem_rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) mem_rsp_valid = 1'b1;
      end else if (mem_req) begin
        if (gwait > 0) gwait--;
        else begin mem_gnt = 1'b1; pend = rd_cfg; gwait = gd_cfg; end
      end else gwait = gd_cfg;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  initial begin
    logic        p_hold;
    logic [21:0] p_cmd, e;
    logic [1:0]  h;
    p_hold = 1'b0; p_cmd = '0;
    forever begin
      @(negedge clock);
      if (reset) p_hold = 1'b0;
      else begin
        if (p_hold) begin
          check("mem_hold_req", mem_req, 1'b1);
          check("mem_hold_cmd", {mem_we, mem_addr}, p_cmd);
        end
        p_hold = mem_req && !mem_gnt;
        p_cmd  = {mem_we, mem_addr};
        if (mem_req && mem_gnt) begin
          if (mem_q.size() == 0) begin
            chk++; err++;
            $display("FAIL mem_unexpected actual=%0h required=none", {mem_we, mem_addr});
          end else begin
            e = mem_q.pop_front();
            check("mem_txn", {mem_we, mem_addr}, e);
          end
        end
        if (fill_done) begin
          if (fill_q.size() == 0) begin
            chk++; err++;
            $display("FAIL fill_unexpected actual=%0h required=none", {fill_set, fill_way, fill_tag});
          end else begin
            e = fill_q.pop_front();
            check("fill", {fill_set, fill_way, fill_tag}, e);
            check("fill_lru", {lru_update_req, lru_update_set, lru_update_way}, {1'b1, e[21:20]});
            check("fill_hit_stall", hit_stall, hit_req);
          end
        end else if (lru_update_req) begin
          check("hit_stall", hit_stall, 1'b0);
          if (hit_q.size() == 0) begin
            chk++; err++;
            $display("FAIL lru_unexpected actual=%0h required=none", {lru_update_set, lru_update_way});
          end else begin
            h = hit_q.pop_front();
            check("hit_lru", {lru_update_set, lru_update_way}, h);
          end
        end
      end
    end
  end

  task automatic do_miss(input logic s, input logic [19:0] t, input logic st, input logic lw,
                         input logic ew, input logic wb, input logic [19:0] wbt,
                         input int en, input bit hm);
    int n;
    bit done;
    lru_way = lw;
    if (wb) mem_q.push_back({1'b1, wbt, s});
    mem_q.push_back({1'b0, t, s});
    fill_q.push_back({s, ew, t});
    miss_req = 1'b1; miss_set = s; miss_tag = t; miss_is_store = st;
    @(posedge clock); #1;
    miss_req = 1'b0; n = 0; done = 1'b0;
    while (!done) begin
      hit_req = 1'b0; hit_is_store = 1'b0;
      if (hm && n == 3) begin
        hit_req = 1'b1; hit_set = 1'b0; hit_way = 1'b1; hit_is_store = 1'b1;
        hit_q.push_back(2'b01);
      end
      if (hm && n == en) begin
        hit_req = 1'b1; hit_set = 1'b0; hit_way = 1'b1;
      end
      @(negedge clock);
      if (n == 0)
        check("victim_query", {lru_victim_req, lru_victim_set, tag_rd_way}, {1'b1, s, ew});
      if (fill_done) done = 1'b1;
      else if (n > 300) begin
        chk++; err++;
        $display("FAIL miss_timeout actual=%0d required=%0d", n, en);
        done = 1'b1;
      end else begin
        @(posedge clock); #1; n++;
      end
    end
    hit_req = 1'b0; hit_is_store = 1'b0;
    check("miss_latency", n, en);
    tag_mem[s][ew] = t;
    @(posedge clock); #1;
  endtask

  task automatic do_hit(input logic s, input logic w, input logic st);
    hit_req = 1'b1; hit_set = s; hit_way = w; hit_is_store = st;
    hit_q.push_back({s, w});
    @(posedge clock); #1;
    hit_req = 1'b0; hit_is_store = 1'b0;
  endtask

  initial begin
    chk = 0; err = 0; gd_cfg = 0; rd_cfg = 3; lru_way = 1'b0;
    for (int s = 0; s < 2; s++) for (int w = 0; w < 2; w++) tag_mem[s][w] = '0;
    reset = 1'b1; miss_req = 1'b0; miss_set = 1'b0; miss_tag = '0; miss_is_store = 1'b0;
    hit_req = 1'b0; hit_set = 1'b0; hit_way = 1'b0; hit_is_store = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_outputs",
          {miss_ready, mem_req, fill_done, lru_victim_req, lru_update_req, hit_stall},
          6'b100000);
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;

    do_miss(1'b1, 20'h00ABC, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 5, 1'b0);
    gd_cfg = 5;
    do_miss(1'b1, 20'h12345, 1'b0, 1'b0, FEAT ? 1'b1 : 1'b0, !FEAT, 20'h00ABC,
            FEAT ? 10 : 19, 1'b0);
    gd_cfg = 0;
    do_miss(1'b0, 20'h00111, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 5, 1'b1);
    do_miss(1'b0, 20'h00222, 1'b1, 1'b0, FEAT ? 1'b1 : 1'b0, 1'b0, 20'h0, 5, 1'b0);
    do_miss(1'b0, 20'h00333, 1'b0, 1'b1, 1'b1, FEAT, 20'h00222, FEAT ? 9 : 5, 1'b0);
    do_hit(1'b1, 1'b0, 1'b1);
    do_hit(1'b0, 1'b1, 1'b0);

    // Reset while waiting on the writeback response; the late response must be ignored.
    rd_cfg = 5; lru_way = 1'b0;
    mem_q.push_back({1'b1, FEAT ? 20'h00ABC : 20'h12345, 1'b1});
    miss_req = 1'b1; miss_set = 1'b1; miss_tag = 20'h0BEEF; miss_is_store = 1'b0;
    @(posedge clock); #1; miss_req = 1'b0;
    repeat (2) @(posedge clock);
    #1; reset = 1'b1;
    @(negedge clock);
    check("rst_mid_ready", {miss_ready, mem_req}, 2'b10);
    @(posedge clock); #1; reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("post_rst_idle", {miss_ready, mem_req, fill_done}, 3'b100);
    end
    @(posedge clock); #1; rd_cfg = 3;

    do_miss(1'b1, 20'h0CAFE, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 5, 1'b0);
    do_miss(1'b0, 20'h00444, 1'b0, 1'b1, FEAT ? 1'b0 : 1'b1, 1'b0, 20'h0, 5, 1'b0);

    repeat (5) @(negedge clock);
    check("mem_q_empty", mem_q.size(), 0);
    check("fill_q_empty", fill_q.size(), 0);
    check("hit_q_empty", hit_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
`default_nettype wire
